// File: rtl/usr_pkg.sv
// Shared definitions for the universal shift register: the mode select width
// and its named encodings.
package usr_pkg;

  localparam int USR_MODE_W = 3;

  typedef enum logic [USR_MODE_W-1:0] {
    MODE_HOLD  = 3'b000,
    MODE_SHR   = 3'b001,
    MODE_SHL   = 3'b010,
    MODE_ROR   = 3'b011,
    MODE_ROL   = 3'b100,
    MODE_LOAD  = 3'b101,
    MODE_CNTUP = 3'b110,
    MODE_CNTDN = 3'b111
  } usr_mode_e;

endpackage : usr_pkg

// File: rtl/univ_shift_reg.sv
// WIDTH-bit universal register: hold, shift, rotate, load and count modes with
// serial cascade ports and a registered counter-wrap pulse.
module univ_shift_reg
  import usr_pkg::*;
#(
  parameter int          WIDTH     = 8,
  parameter logic [63:0] RESET_VAL = 64'd0
) (
  input  logic                  clk_in,
  input  logic                  rst_n_in,
  input  logic                  en_in,
  input  logic [USR_MODE_W-1:0] mode_in,
  input  logic [WIDTH-1:0]      d_in,
  input  logic                  ser_msb_in,
  input  logic                  ser_lsb_in,
  output logic [WIDTH-1:0]      q_out,
  output logic                  ser_msb_out,
  output logic                  ser_lsb_out,
  output logic                  wrap_out
);

  generate
    if (WIDTH < 1 || WIDTH > 64) begin : g_bad_width
      $error("univ_shift_reg: WIDTH must be in 1..64");
    end
  endgenerate

  localparam logic [WIDTH-1:0] RST_Q = RESET_VAL[WIDTH-1:0];

  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] q_nxt;
  logic             wrap_q;
  logic             wrap_nxt;

  // Shift-based forms stay legal at WIDTH=1, where part-selects like
  // q[WIDTH-2:0] would be reversed; there they reduce to the serial bit or hold.
  logic [WIDTH-1:0] shr_val, shl_val, ror_val, rol_val;

  always_comb begin
    shr_val = (q >> 1) | (WIDTH'(ser_msb_in) << (WIDTH - 1));
    shl_val = (q << 1) | WIDTH'(ser_lsb_in);
    ror_val = (q >> 1) | (WIDTH'(q[0]) << (WIDTH - 1));
    rol_val = (q << 1) | WIDTH'(q[WIDTH-1]);
  end

  // NOTE: every output of a combinational block gets a default first so no
  // path through the case leaves it unassigned and infers a latch.
  always_comb begin
    q_nxt    = q;
    wrap_nxt = 1'b0;
    case (usr_mode_e'(mode_in))
      MODE_HOLD:  q_nxt = q;
      MODE_SHR:   q_nxt = shr_val;
      MODE_SHL:   q_nxt = shl_val;
      MODE_ROR:   q_nxt = ror_val;
      MODE_ROL:   q_nxt = rol_val;
      MODE_LOAD:  q_nxt = d_in;
      MODE_CNTUP: begin
        q_nxt    = q + 1'b1;
        wrap_nxt = &q;
      end
      MODE_CNTDN: begin
        q_nxt    = q - 1'b1;
        wrap_nxt = ~|q;
      end
      default:    q_nxt = q;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments; reset is sampled on
  // the clock edge, so it sits inside the clocked block, not in the sensitivity list.
  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      q      <= RST_Q;
      wrap_q <= 1'b0;
    end else if (!en_in) begin
      wrap_q <= 1'b0;
    end else begin
      q      <= q_nxt;
      wrap_q <= wrap_nxt;
    end
  end

  assign q_out       = q;
  assign ser_msb_out = q[WIDTH-1];
  assign ser_lsb_out = q[0];
  assign wrap_out    = wrap_q;

endmodule : univ_shift_reg

// File: tb/tb_univ_shift_reg.sv
// Directed bench for univ_shift_reg: an 8-bit instance, a chained pair of
// 4-bit instances and a 1-bit instance, checked with immediate assertions.
module tb_univ_shift_reg;
  import usr_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;

  logic rst_n;
  logic en;

  // 8-bit main instance
  logic [2:0] m_mode;
  logic [7:0] m_d;
  logic       m_smsb, m_slsb;
  logic [7:0] m_q;
  logic       m_omsb, m_olsb, m_wrap;

  univ_shift_reg #(.WIDTH(8)) u_main (
    .clk_in(clk), .rst_n_in(rst_n), .en_in(en), .mode_in(m_mode), .d_in(m_d),
    .ser_msb_in(m_smsb), .ser_lsb_in(m_slsb), .q_out(m_q),
    .ser_msb_out(m_omsb), .ser_lsb_out(m_olsb), .wrap_out(m_wrap)
  );

  // Chained 4-bit pair: hi.ser_lsb_out feeds lo.ser_msb_in
  logic [2:0] c_mode;
  logic [3:0] c_hi_d, c_lo_d;
  logic       c_smsb;
  logic [3:0] c_hi_q, c_lo_q;
  logic       c_link, c_hi_omsb, c_hi_wrap, c_lo_omsb, c_lo_olsb, c_lo_wrap;

  univ_shift_reg #(.WIDTH(4)) u_hi (
    .clk_in(clk), .rst_n_in(rst_n), .en_in(en), .mode_in(c_mode), .d_in(c_hi_d),
    .ser_msb_in(c_smsb), .ser_lsb_in(1'b0), .q_out(c_hi_q),
    .ser_msb_out(c_hi_omsb), .ser_lsb_out(c_link), .wrap_out(c_hi_wrap)
  );

  univ_shift_reg #(.WIDTH(4), .RESET_VAL(64'h15A)) u_lo (
    .clk_in(clk), .rst_n_in(rst_n), .en_in(en), .mode_in(c_mode), .d_in(c_lo_d),
    .ser_msb_in(c_link), .ser_lsb_in(1'b0), .q_out(c_lo_q),
    .ser_msb_out(c_lo_omsb), .ser_lsb_out(c_lo_olsb), .wrap_out(c_lo_wrap)
  );

  // 1-bit instance
  logic [2:0] s_mode;
  logic       s_d, s_smsb, s_slsb;
  logic       s_q, s_omsb, s_olsb, s_wrap;

  univ_shift_reg #(.WIDTH(1)) u_one (
    .clk_in(clk), .rst_n_in(rst_n), .en_in(en), .mode_in(s_mode), .d_in(s_d),
    .ser_msb_in(s_smsb), .ser_lsb_in(s_slsb), .q_out(s_q),
    .ser_msb_out(s_omsb), .ser_lsb_out(s_olsb), .wrap_out(s_wrap)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle before sampling.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n  = 1'b0;
    en     = 1'b1;
    m_mode = MODE_LOAD;  m_d = 8'hFF; m_smsb = 1'b0; m_slsb = 1'b0;
    c_mode = MODE_LOAD;  c_hi_d = 4'hF; c_lo_d = 4'hF; c_smsb = 1'b0;
    s_mode = MODE_LOAD;  s_d = 1'b1; s_smsb = 1'b0; s_slsb = 1'b0;

    // Reset overrides enable and LOAD
    tick();
    tick();
    check("rst_q", m_q, 8'h00);
    check("rst_wrap", m_wrap, 1'b0);
    check("rst_lo_trunc", c_lo_q, 4'hA);
    check("rst_one", s_q, 1'b0);

    rst_n  = 1'b1;
    m_d    = 8'hA5;
    c_mode = MODE_HOLD;
    s_mode = MODE_HOLD;
    tick();
    check("load_a5", m_q, 8'hA5);

    // Shift and rotate
    m_mode = MODE_SHR; m_smsb = 1'b1;
    tick();
    check("shr", m_q, 8'hD2);
    m_mode = MODE_SHL; m_slsb = 1'b0;
    tick();
    check("shl", m_q, 8'hA4);
    check("ser_msb_out", m_omsb, 1'b1);
    check("ser_lsb_out", m_olsb, 1'b0);
    m_mode = MODE_ROR;
    tick();
    check("ror", m_q, 8'h52);
    m_mode = MODE_ROL;
    tick();
    check("rol", m_q, 8'hA4);

    // Count up across the all-ones boundary
    m_mode = MODE_LOAD; m_d = 8'hFE;
    tick();
    m_mode = MODE_CNTUP;
    tick();
    check("up_ff", m_q, 8'hFF);
    check("up_ff_wrap", m_wrap, 1'b0);
    tick();
    check("up_00", m_q, 8'h00);
    check("up_00_wrap", m_wrap, 1'b1);
    tick();
    check("up_01", m_q, 8'h01);
    check("up_01_wrap", m_wrap, 1'b0);

    // Count down across zero
    m_mode = MODE_LOAD; m_d = 8'h01;
    tick();
    m_mode = MODE_CNTDN;
    tick();
    check("dn_00", m_q, 8'h00);
    check("dn_00_wrap", m_wrap, 1'b0);
    tick();
    check("dn_ff", m_q, 8'hFF);
    check("dn_ff_wrap", m_wrap, 1'b1);
    m_mode = MODE_HOLD;
    tick();
    check("hold_ff", m_q, 8'hFF);
    check("hold_wrap", m_wrap, 1'b0);

    // Reset during a wrapping count discards the count and the wrap
    m_mode = MODE_CNTUP; rst_n = 1'b0;
    tick();
    check("rst_cnt_q", m_q, 8'h00);
    check("rst_cnt_wrap", m_wrap, 1'b0);
    rst_n = 1'b1;

    // Enable low freezes the register
    m_mode = MODE_LOAD; m_d = 8'h3C;
    tick();
    en = 1'b0; m_mode = MODE_CNTUP;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("en0_q", m_q, 8'h3C);
      check("en0_wrap", m_wrap, 1'b0);
    end
    en = 1'b1; rst_n = 1'b0; m_mode = MODE_LOAD; m_d = 8'h77;
    tick();
    check("rst_over_load", m_q, 8'h00);
    rst_n = 1'b1; m_mode = MODE_HOLD;

    // Chained 8-bit shift right: 0x81 -> 0x40
    c_mode = MODE_LOAD; c_hi_d = 4'h8; c_lo_d = 4'h1;
    tick();
    c_mode = MODE_SHR; c_smsb = 1'b0;
    tick();
    check("chain1_hi", c_hi_q, 4'h4);
    check("chain1_lo", c_lo_q, 4'h0);
    // 0x91 with a 1 shifted in -> 0xC8, crossing the link
    c_mode = MODE_LOAD; c_hi_d = 4'h9; c_lo_d = 4'h1;
    tick();
    c_mode = MODE_SHR; c_smsb = 1'b1;
    tick();
    check("chain2_hi", c_hi_q, 4'hC);
    check("chain2_lo", c_lo_q, 4'h8);
    c_mode = MODE_HOLD;

    // WIDTH=1: continuous counting pulses wrap every other cycle
    s_mode = MODE_CNTUP;
    tick();
    check("one_up1", s_q, 1'b1);
    check("one_up1_wrap", s_wrap, 1'b0);
    tick();
    check("one_up0", s_q, 1'b0);
    check("one_up0_wrap", s_wrap, 1'b1);
    tick();
    check("one_up1b_wrap", s_wrap, 1'b0);
    s_mode = MODE_SHR; s_smsb = 1'b0;
    tick();
    check("one_shr", s_q, 1'b0);
    check("one_ser_same", {s_omsb, s_olsb}, 2'b00);
    s_mode = MODE_SHL; s_slsb = 1'b1;
    tick();
    check("one_shl", s_q, 1'b1);
    check("one_ser_msb", s_omsb, 1'b1);
    s_mode = MODE_ROR;
    tick();
    check("one_ror", s_q, 1'b1);
    s_mode = MODE_ROL;
    tick();
    check("one_rol", s_q, 1'b1);
    s_mode = MODE_CNTDN;
    tick();
    check("one_dn0", s_q, 1'b0);
    check("one_dn0_wrap", s_wrap, 1'b0);
    tick();
    check("one_dn1", s_q, 1'b1);
    check("one_dn1_wrap", s_wrap, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule : tb_univ_shift_reg
